// File: rtl/bp_fe_pkg.sv
// Shared types for the FE branch-history-table controller.
// No logic; types and default parameter values only.
// Update-queue entry shape depends on the BHT index width, so it is built by macro.

`ifndef BP_FE_PKG_MACROS
`define BP_FE_PKG_MACROS
`define DECLARE_BP_FE_BHT_UPD_S(idx_width_mp) \
    typedef struct packed { \
        logic [idx_width_mp-1:0] idx; \
        logic                    taken; \
    } bp_fe_bht_upd_s
`endif

package bp_fe_pkg;

    // Controller states: init sweep, arbitration, write half of an update RMW
    typedef enum logic [1:0] {
        e_bht_init   = 2'd0,
        e_bht_idle   = 2'd1,
        e_bht_upd_wr = 2'd2
    } bp_fe_bht_ctrl_state_e;

    localparam int bp_fe_bht_idx_width_dflt = 4;
    localparam int bp_fe_cnt_sat_bits_dflt  = 2;
    localparam int bp_fe_init_cnt_dflt      = 1;
    localparam int bp_fe_upd_fifo_els_dflt  = 4;

endpackage

// File: rtl/bp_fe_bht.sv
// Saturating-counter step used by the BHT controller for update RMW.
// Latency: combinational.
// Backpressure: none.

module bp_fe_bht_sat #(
    parameter int cnt_w_p = 2
) (
    input  logic [cnt_w_p-1:0] i_cnt,
    input  logic               i_taken,
    output logic [cnt_w_p-1:0] o_cnt
);

    // Step toward the resolved direction, holding at either end so the counter never wraps
    always_comb begin
        o_cnt = i_cnt;
        if (i_taken) begin
            if (i_cnt != '1) begin
                o_cnt = i_cnt + 1'b1;
            end
        end else begin
            if (i_cnt != '0) begin
                o_cnt = i_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/bp_fe_bht_ctrl_fifo.sv
// Small 1-read/1-write FIFO with registered storage and an occupancy counter.
// Latency: data written is visible at data_o the cycle after the push.
// Backpressure: ready_o drops when full; no push-when-full bypass, push+pop allowed otherwise.

module bsg_fifo_1r1w_small #(
    parameter int width_p = 8,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(els_p + 1);
    localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(els_p - 1);
    localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(els_p);

    logic [width_p-1:0]  r_mem [els_p];
    logic [ptr_w_lp-1:0] r_wr_ptr;
    logic [ptr_w_lp-1:0] r_rd_ptr;
    logic [cnt_w_lp-1:0] r_cnt;
    logic                w_push;
    logic                w_pop;

    assign ready_o = (r_cnt != full_cnt_lp);
    assign v_o     = (r_cnt != '0);
    assign data_o  = r_mem[r_rd_ptr];
    assign w_push  = v_i & ready_o;
    assign w_pop   = yumi_i & v_o;

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    // Pointers and occupancy; pointers wrap explicitly so non-power-of-2 depths work
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == last_ptr_lp) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == last_ptr_lp) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/bp_fe_bht_ctrl.sv
// Single-port BHT controller: init sweep, lookup/update arbitration, update RMW.
// Latency: prediction 1 cycle after lookup accept; each queued update costs 2 SRAM cycles.
// Backpressure: r_ready_o low during init and update RMW; w_ready_o low during init or queue full.

module bp_fe_bht_ctrl
    import bp_fe_pkg::*;
#(
    parameter int bht_idx_width_p   = bp_fe_bht_idx_width_dflt,
    parameter int bp_cnt_sat_bits_p = bp_fe_cnt_sat_bits_dflt,
    parameter int bp_init_cnt_p     = bp_fe_init_cnt_dflt,
    parameter int upd_fifo_els_p    = bp_fe_upd_fifo_els_dflt
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,

    input  logic                         r_v_i,
    input  logic [bht_idx_width_p-1:0]   idx_r_i,
    output logic                         r_ready_o,
    output logic                         predict_v_o,
    output logic                         predict_o,

    input  logic                         w_v_i,
    input  logic [bht_idx_width_p-1:0]   idx_w_i,
    input  logic                         taken_i,
    output logic                         w_ready_o,

    output logic                         mem_v_o,
    output logic                         mem_w_o,
    output logic [bht_idx_width_p-1:0]   mem_addr_o,
    output logic [bp_cnt_sat_bits_p-1:0] mem_data_o,
    input  logic [bp_cnt_sat_bits_p-1:0] mem_data_i,

    output logic                         init_done_o
);

    `DECLARE_BP_FE_BHT_UPD_S(bht_idx_width_p);

    localparam logic [bp_cnt_sat_bits_p-1:0] init_cnt_lp = bp_cnt_sat_bits_p'(bp_init_cnt_p);

    bp_fe_bht_ctrl_state_e r_state;
    bp_fe_bht_ctrl_state_e w_state_n;

    logic [bht_idx_width_p-1:0]   r_init_cnt;
    logic                         r_init_done;
    logic                         r_lookup_issued;

    bp_fe_bht_upd_s               w_upd_in;
    bp_fe_bht_upd_s               w_head;
    logic                         w_fifo_ready;
    logic                         w_fifo_v;
    logic                         w_fifo_yumi;
    logic                         w_upd_first;
    logic                         w_init_last;
    logic [bp_cnt_sat_bits_p-1:0] w_sat_cnt;

    logic                         w_mem_v;
    logic                         w_mem_w;
    logic [bht_idx_width_p-1:0]   w_mem_addr;
    logic [bp_cnt_sat_bits_p-1:0] w_mem_data;
    logic                         w_r_ready;
    logic                         w_lookup_fire;

    assign w_upd_in.idx   = idx_w_i;
    assign w_upd_in.taken = taken_i;

    // Pushes are only admitted once the table has been cleared
    bsg_fifo_1r1w_small #(
        .width_p ($bits(bp_fe_bht_upd_s)),
        .els_p   (upd_fifo_els_p)
    ) u_upd_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (w_v_i & r_init_done),
        .data_i    (w_upd_in),
        .ready_o   (w_fifo_ready),
        .v_o       (w_fifo_v),
        .data_o    (w_head),
        .yumi_i    (w_fifo_yumi)
    );

    bp_fe_bht_sat #(
        .cnt_w_p (bp_cnt_sat_bits_p)
    ) u_sat (
        .i_cnt   (mem_data_i),
        .i_taken (w_head.taken),
        .o_cnt   (w_sat_cnt)
    );

    // Updates win when the queue is full, or when nobody is asking for a lookup
    assign w_upd_first = ~w_fifo_ready | (w_fifo_v & ~r_v_i);
    assign w_init_last = (r_init_cnt == '1);

    // State register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= e_bht_init;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_n = r_state;
        case (r_state)
            e_bht_init:   if (w_init_last) w_state_n = e_bht_idle;
            e_bht_idle:   if (w_upd_first) w_state_n = e_bht_upd_wr;
            e_bht_upd_wr: w_state_n = e_bht_idle;
            default:      w_state_n = e_bht_init;
        endcase
    end

    // Per-state SRAM command, handshake and queue-pop decode
    always_comb begin
        w_mem_v       = 1'b0;
        w_mem_w       = 1'b0;
        w_mem_addr    = '0;
        w_mem_data    = '0;
        w_r_ready     = 1'b0;
        w_fifo_yumi   = 1'b0;
        w_lookup_fire = 1'b0;
        case (r_state)
            e_bht_init: begin
                w_mem_v    = 1'b1;
                w_mem_w    = 1'b1;
                w_mem_addr = r_init_cnt;
                w_mem_data = init_cnt_lp;
            end
            e_bht_idle: begin
                if (w_upd_first) begin
                    w_mem_v    = 1'b1;
                    w_mem_addr = w_head.idx;
                end else if (r_v_i) begin
                    w_mem_v       = 1'b1;
                    w_mem_addr    = idx_r_i;
                    w_r_ready     = 1'b1;
                    w_lookup_fire = 1'b1;
                end
            end
            e_bht_upd_wr: begin
                w_mem_v     = 1'b1;
                w_mem_w     = 1'b1;
                w_mem_addr  = w_head.idx;
                w_mem_data  = w_sat_cnt;
                w_fifo_yumi = 1'b1;
            end
            default: ;
        endcase
    end

    // Init sweep progress, sticky done flag and the lookup-in-flight marker
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_init_cnt      <= '0;
            r_init_done     <= 1'b0;
            r_lookup_issued <= 1'b0;
        end else begin
            if (r_state == e_bht_init) begin
                r_init_cnt <= r_init_cnt + 1'b1;
                if (w_init_last) begin
                    r_init_done <= 1'b1;
                end
            end
            r_lookup_issued <= w_lookup_fire;
        end
    end

    // SRAM port is held quiet while reset is asserted, even though the FSM sits in init
    assign mem_v_o     = reset_n_i & w_mem_v;
    assign mem_w_o     = reset_n_i & w_mem_w;
    assign mem_addr_o  = reset_n_i ? w_mem_addr : '0;
    assign mem_data_o  = reset_n_i ? w_mem_data : '0;

    assign r_ready_o   = w_r_ready;
    assign w_ready_o   = r_init_done & w_fifo_ready;
    assign init_done_o = r_init_done;
    assign predict_v_o = r_lookup_issued;
    assign predict_o   = r_lookup_issued & mem_data_i[bp_cnt_sat_bits_p-1];

endmodule

// File: tb/tb_bp_fe_bht_ctrl.sv
// Scoreboard bench for bp_fe_bht_ctrl with a behavioural 1RW SRAM.
module tb_bp_fe_bht_ctrl;

    logic       clk = 1'b0;
    logic       reset_n_i = 1'b0;
    logic       r_v_i = 1'b0;
    logic [3:0] idx_r_i = '0;
    logic       r_ready_o;
    logic       predict_v_o;
    logic       predict_o;
    logic       w_v_i = 1'b0;
    logic [3:0] idx_w_i = '0;
    logic       taken_i = 1'b0;
    logic       w_ready_o;
    logic       mem_v_o;
    logic       mem_w_o;
    logic [3:0] mem_addr_o;
    logic [1:0] mem_data_o;
    logic [1:0] mem_data_i = '0;
    logic       init_done_o;

    int errors = 0;
    int checks = 0;

    typedef struct { logic [3:0] addr; logic [1:0] data; } wr_t;
    wr_t  exp_wr[$];
    logic exp_pred[$];
    int   model[16];
    logic [1:0] sram[16];
    wr_t  mon_w;
    logic mon_p;

    always #5 clk = ~clk;

    bp_fe_bht_ctrl #(
        .bht_idx_width_p(4), .bp_cnt_sat_bits_p(2), .bp_init_cnt_p(1), .upd_fifo_els_p(4)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n_i),
        .r_v_i(r_v_i), .idx_r_i(idx_r_i), .r_ready_o(r_ready_o),
        .predict_v_o(predict_v_o), .predict_o(predict_o),
        .w_v_i(w_v_i), .idx_w_i(idx_w_i), .taken_i(taken_i), .w_ready_o(w_ready_o),
        .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
        .init_done_o(init_done_o)
    );

    // Behavioural single-port SRAM, read data one cycle after the read
    always @(posedge clk) begin
        if (mem_v_o) begin
            if (mem_w_o) sram[mem_addr_o] <= mem_data_o;
            else         mem_data_i <= sram[mem_addr_o];
        end
    end

    function automatic int sat(input int c, input bit t);
        if (t) return (c < 3) ? c + 1 : 3;
        return (c > 0) ? c - 1 : 0;
    endfunction

    // Pop-and-compare on every prediction and every post-init SRAM write
    always @(negedge clk) begin
        if (reset_n_i) begin
            if (predict_v_o) begin
                checks++;
                if (exp_pred.size() == 0) begin
                    errors++;
                    $display("FAIL pred_unexpected: predict_v_o=1 predict_o=%0b, required no prediction", predict_o);
                end else begin
                    mon_p = exp_pred.pop_front();
                    if (predict_o !== mon_p) begin
                        errors++;
                        $display("FAIL pred_value: got %0b, required %0b", predict_o, mon_p);
                    end
                end
            end
            if (mem_v_o && mem_w_o && init_done_o) begin
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected: addr=%0d data=%0d, required no write", mem_addr_o, mem_data_o);
                end else begin
                    mon_w = exp_wr.pop_front();
                    if (mem_addr_o !== mon_w.addr || mem_data_o !== mon_w.data) begin
                        errors++;
                        $display("FAIL wr_value: got addr=%0d data=%0d, required addr=%0d data=%0d",
                                 mem_addr_o, mem_data_o, mon_w.addr, mon_w.data);
                    end
                end
            end
        end
    end

    // One cycle of stimulus; records expectations for accepted transactions
    task automatic drive(input bit rv, input logic [3:0] ridx, input bit wv, input logic [3:0] widx,
                         input bit tk, output bit r_acc, output bit w_acc);
        @(negedge clk);
        r_v_i = rv; idx_r_i = ridx; w_v_i = wv; idx_w_i = widx; taken_i = tk;
        #1;
        r_acc = rv && r_ready_o;
        w_acc = wv && w_ready_o;
        if (r_acc) exp_pred.push_back(model[ridx] >= 2);
        if (w_acc) begin
            model[widx] = sat(model[widx], tk);
            exp_wr.push_back('{widx, 2'(model[widx])});
        end
    endtask

    task automatic idle(input int n);
        bit ra, wa;
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, ra, wa);
    endtask

    task automatic drain;
        bit ra, wa;
        for (int i = 0; i < 60 && exp_wr.size() != 0; i++) drive(0, 0, 0, 0, 0, ra, wa);
        idle(2);
        checks++;
        if (exp_wr.size() != 0 || exp_pred.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d writes and %0d predictions outstanding, required 0",
                     exp_wr.size(), exp_pred.size());
        end
    endtask

    task automatic push_upd(input logic [3:0] idx, input bit tk);
        bit ra, wa;
        wa = 0;
        for (int i = 0; i < 20 && !wa; i++) drive(0, 0, 1, idx, tk, ra, wa);
        checks++;
        if (!wa) begin errors++; $display("FAIL push_timeout: idx=%0d never accepted", idx); end
    endtask

    task automatic lookup(input logic [3:0] idx);
        bit ra, wa;
        ra = 0;
        for (int i = 0; i < 20 && !ra; i++) drive(1, idx, 0, 0, 0, ra, wa);
        checks++;
        if (!ra) begin errors++; $display("FAIL lookup_timeout: idx=%0d never accepted", idx); end
        idle(1);
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if ({mem_v_o, mem_w_o, mem_addr_o, mem_data_o, r_ready_o, w_ready_o,
             predict_v_o, predict_o, init_done_o} !== '0) begin
            errors++;
            $display("FAIL %s: outputs v=%0b w=%0b a=%0d d=%0d rr=%0b wr=%0b pv=%0b p=%0b done=%0b, required all 0",
                     name, mem_v_o, mem_w_o, mem_addr_o, mem_data_o, r_ready_o, w_ready_o,
                     predict_v_o, predict_o, init_done_o);
        end
    endtask

    // Release reset and follow the 16-entry sweep with requests pending throughout
    task automatic test_init_sweep;
        @(negedge clk);
        reset_n_i = 1'b1; r_v_i = 1'b1; w_v_i = 1'b1; idx_w_i = 4'd0; idx_r_i = 4'd0;
        for (int k = 0; k < 16; k++) begin
            #1;
            checks++;
            if (mem_v_o !== 1'b1 || mem_w_o !== 1'b1 || mem_addr_o !== 4'(k) || mem_data_o !== 2'd1 ||
                r_ready_o !== 1'b0 || w_ready_o !== 1'b0 || init_done_o !== 1'b0) begin
                errors++;
                $display("FAIL init_cycle%0d: v=%0b w=%0b a=%0d d=%0d rr=%0b wr=%0b done=%0b, required 1 1 %0d 1 0 0 0",
                         k, mem_v_o, mem_w_o, mem_addr_o, mem_data_o, r_ready_o, w_ready_o, init_done_o, k);
            end
            @(negedge clk);
        end
        r_v_i = 1'b0; w_v_i = 1'b0;
        #1;
        checks++;
        if (init_done_o !== 1'b1 || mem_v_o !== 1'b0 || w_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL init_done: done=%0b mem_v=%0b w_ready=%0b, required 1 0 1", init_done_o, mem_v_o, w_ready_o);
        end
        for (int i = 0; i < 16; i++) model[i] = 1;
    endtask

    task automatic test_reset;
        #12;
        check_outputs_zero("reset_values");
        test_init_sweep();
    endtask

    task automatic test_lookup_update;
        bit ra, wa;
        lookup(4'd3);
        checks++;
        if (predict_v_o !== 1'b1 || predict_o !== 1'b0) begin
            errors++;
            $display("FAIL first_lookup: pv=%0b p=%0b, required 1 0", predict_v_o, predict_o);
        end
        drive(0, 0, 1, 3, 1, ra, wa);
        drive(0, 0, 1, 3, 1, ra, wa);
        drain();
        lookup(4'd3);
        idle(1);
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 3; i++) push_upd(4'd3, 1);
        drain();
        lookup(4'd3);
        for (int i = 0; i < 5; i++) push_upd(4'd3, 0);
        drain();
        lookup(4'd3);
        checks++;
        if (sram[3] !== 2'd0) begin errors++; $display("FAIL sat_floor: sram[3]=%0d, required 0", sram[3]); end
    endtask

    task automatic test_backpressure;
        int pushed, r_stall, w_stall;
        bit ra, wa;
        pushed = 0; r_stall = 0; w_stall = 0;
        for (int c = 0; c < 20; c++) begin
            drive(1, 5, pushed < 5, 4'(8 + pushed), 1, ra, wa);
            if (!ra) r_stall++;
            if (pushed < 5 && !wa) w_stall++;
            if (wa) pushed++;
        end
        checks++;
        if (pushed != 5 || r_stall != 4 || w_stall != 2) begin
            errors++;
            $display("FAIL backpressure: pushed=%0d r_stall=%0d w_stall=%0d, required 5 4 2", pushed, r_stall, w_stall);
        end
        drain();
        for (int i = 8; i < 13; i++) begin
            checks++;
            if (sram[i] !== 2'd2) begin errors++; $display("FAIL bp_entry%0d: sram=%0d, required 2", i, sram[i]); end
        end
    endtask

    task automatic test_push_pop;
        bit ra, wa;
        drive(1, 5, 1, 1, 1, ra, wa);
        drive(1, 5, 1, 2, 1, ra, wa);
        drive(1, 5, 1, 4, 1, ra, wa);
        drive(0, 0, 0, 0, 0, ra, wa);
        drive(0, 0, 1, 6, 1, ra, wa);
        checks++;
        if (wa !== 1'b1 || r_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL pushpop_accept: w_acc=%0b r_ready=%0b, required 1 0", wa, r_ready_o);
        end
        drive(1, 5, 1, 13, 1, ra, wa);
        checks++;
        if (wa !== 1'b1 || ra !== 1'b1) begin
            errors++;
            $display("FAIL pushpop_fill: w_acc=%0b r_acc=%0b, required 1 1", wa, ra);
        end
        drive(1, 5, 0, 0, 0, ra, wa);
        checks++;
        if (w_ready_o !== 1'b0 || r_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL pushpop_occupancy: w_ready=%0b r_ready=%0b, required 0 0", w_ready_o, r_ready_o);
        end
        drain();
    endtask

    task automatic test_reset_mid_rmw;
        bit ra, wa, seen;
        drive(0, 0, 1, 14, 1, ra, wa);
        drive(0, 0, 1, 15, 0, ra, wa);
        drive(0, 0, 0, 0, 0, ra, wa);
        checks++;
        if (mem_v_o !== 1'b1 || mem_w_o !== 1'b1 || mem_addr_o !== 4'd14) begin
            errors++;
            $display("FAIL rmw_write_phase: v=%0b w=%0b a=%0d, required 1 1 14", mem_v_o, mem_w_o, mem_addr_o);
        end
        reset_n_i = 1'b0;
        #1;
        check_outputs_zero("reset_mid_rmw");
        exp_wr.delete();
        exp_pred.delete();
        test_init_sweep();
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 0, 0, ra, wa);
            if (mem_v_o) seen = 1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL fifo_flushed: mem_v_o=1 after reset, required queue empty"); end
        lookup(4'd14);
        lookup(4'd15);
        drain();
    endtask

    initial begin
        test_reset();
        test_lookup_update();
        test_saturation();
        test_backpressure();
        test_push_pop();
        test_reset_mid_rmw();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required finish");
        $fatal(1, "watchdog");
    end

endmodule
